// File: rtl/core_dbg_itr_if.sv
// rtl/core_dbg_itr_if.sv - signal bundle between core_dbg_itr and its host/core neighbours
// master: host and core side (drives strobes, write data, handshake inputs)
// slave:  core_dbg_itr (drives read data, status, run-control pulses, ITR issue, DTR view)
interface core_dbg_itr_if #(
    parameter int INSN_WIDTH = 32,
    parameter int REG_WIDTH  = 64
);
    logic                  dbg_wr_en;
    logic                  dbg_rd_en;
    logic [3:0]            dbg_addr;
    logic [31:0]           dbg_wdata;
    logic [31:0]           dbg_rdata;
    logic                  dbg_busy;
    logic                  dbg_err;
    logic                  core_halted;
    logic                  halt_req;
    logic                  resume_req;
    logic                  itr_valid;
    logic [INSN_WIDTH-1:0] itr_insn;
    logic                  itr_ready;
    logic                  itr_done;
    logic                  dtr_core_wr_en;
    logic [REG_WIDTH-1:0]  dtr_core_wdata;
    logic [REG_WIDTH-1:0]  dtr_core_rdata;

    modport master (
        output dbg_wr_en, dbg_rd_en, dbg_addr, dbg_wdata,
        output core_halted, itr_ready, itr_done, dtr_core_wr_en, dtr_core_wdata,
        input  dbg_rdata, dbg_busy, dbg_err, halt_req, resume_req,
        input  itr_valid, itr_insn, dtr_core_rdata
    );

    modport slave (
        input  dbg_wr_en, dbg_rd_en, dbg_addr, dbg_wdata,
        input  core_halted, itr_ready, itr_done, dtr_core_wr_en, dtr_core_wdata,
        output dbg_rdata, dbg_busy, dbg_err, halt_req, resume_req,
        output itr_valid, itr_insn, dtr_core_rdata
    );
endinterface

// File: rtl/core_dbg_itr.sv
// rtl/core_dbg_itr.sv - Tachyon debug register block with ITR instruction injection
// Ports: clk, rst (asynchronous, active-high), bus (core_dbg_itr_if.slave):
//   host register port (dbg_*), run-control pulses (halt_req/resume_req),
//   ITR issue handshake (itr_valid/itr_insn/itr_ready/itr_done) and the shared DTR.
module core_dbg_itr #(
    parameter int INSN_WIDTH = 32,
    parameter int REG_WIDTH  = 64
) (
    input  logic          clk,
    input  logic          rst,
    core_dbg_itr_if.slave bus
);
    localparam int HALF = REG_WIDTH / 2;

    typedef enum logic [3:0] {
        REG_DBGSC    = 4'd0,
        REG_DRUNCTRL = 4'd1,
        REG_ITR0     = 4'd2,
        REG_ITR1     = 4'd3,
        REG_ITR2     = 4'd4,
        REG_ITR3     = 4'd5,
        REG_DTR_HI   = 4'd6,
        REG_DTR_LO   = 4'd7
    } dbg_iface_reg_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [1:0]                  idx_q, idx_d;
    logic [1:0]                  itr_len_q, itr_len_d;
    logic [3:0][INSN_WIDTH-1:0]  itr_q, itr_d;
    logic                        err_q, err_d;
    logic                        halt_q, halt_d;
    logic                        resume_q, resume_d;
    logic [31:0]                 rdata_q, rdata_d;
    logic [REG_WIDTH-1:0]        dtr_q, dtr_d;
    logic                        busy;
    logic                        host_dtr_wr;

    assign busy        = (state_q != ST_IDLE);
    assign host_dtr_wr = bus.dbg_wr_en &&
                         (bus.dbg_addr == REG_DTR_HI || bus.dbg_addr == REG_DTR_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            itr_len_q <= 2'd3;
            itr_q     <= '0;
            err_q     <= 1'b0;
            halt_q    <= 1'b0;
            resume_q  <= 1'b0;
            rdata_q   <= 32'd0;
            dtr_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            itr_len_q <= itr_len_d;
            itr_q     <= itr_d;
            err_q     <= err_d;
            halt_q    <= halt_d;
            resume_q  <= resume_d;
            rdata_q   <= rdata_d;
            dtr_q     <= dtr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        itr_len_d = itr_len_q;
        itr_d     = itr_q;
        err_d     = err_q;
        halt_d    = 1'b0;
        resume_d  = 1'b0;
        rdata_d   = rdata_q;
        dtr_d     = dtr_q;

        if (bus.dbg_wr_en) begin
            case (bus.dbg_addr)
                REG_DBGSC: begin
                    itr_len_d = bus.dbg_wdata[1:0];
                    if (bus.dbg_wdata[2]) err_d = 1'b0;
                end
                REG_DRUNCTRL: begin
                    // halt wins over resume; resume would race an in-flight sequence
                    halt_d   = bus.dbg_wdata[0];
                    resume_d = bus.dbg_wdata[1] & ~bus.dbg_wdata[0] & ~busy;
                end
                REG_ITR0, REG_ITR1, REG_ITR2: begin
                    // offsets 2,3,4 map to slots 0,1,2 via low two address bits + 2 (mod 4)
                    if (busy) err_d = 1'b1;
                    else      itr_d[bus.dbg_addr[1:0] + 2'd2] = bus.dbg_wdata[INSN_WIDTH-1:0];
                end
                REG_ITR3: begin
                    if (busy) begin
                        err_d = 1'b1;
                    end else begin
                        itr_d[3] = bus.dbg_wdata[INSN_WIDTH-1:0];
                        if (bus.core_halted) begin
                            state_d = ST_ISSUE;
                            idx_d   = 2'd0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                REG_DTR_HI: dtr_d[REG_WIDTH-1:HALF] = bus.dbg_wdata[HALF-1:0];
                REG_DTR_LO: dtr_d[HALF-1:0]         = bus.dbg_wdata[HALF-1:0];
                default: ;
            endcase
        end

        // core owns the DTR on a collision; the lost host write is flagged
        if (bus.dtr_core_wr_en) begin
            dtr_d = bus.dtr_core_wdata;
            if (host_dtr_wr) err_d = 1'b1;
        end

        // evaluated last so an abort error cannot be masked by a same-cycle DBGSC clear
        case (state_q)
            ST_ISSUE: begin
                if (!bus.core_halted) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (bus.itr_ready) begin
                    if (idx_q == itr_len_q) state_d = ST_WAIT;
                    else                    idx_d   = idx_q + 2'd1;
                end
            end
            ST_WAIT: begin
                if (bus.itr_done) state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (bus.dbg_rd_en) begin
            case (bus.dbg_addr)
                REG_DTR_HI: rdata_d = dtr_q[REG_WIDTH-1:HALF];
                REG_DTR_LO: rdata_d = dtr_q[HALF-1:0];
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    assign bus.dbg_rdata      = rdata_q;
    assign bus.dbg_busy       = busy;
    assign bus.dbg_err        = err_q;
    assign bus.halt_req       = halt_q;
    assign bus.resume_req     = resume_q;
    assign bus.itr_valid      = (state_q == ST_ISSUE);
    assign bus.itr_insn       = (state_q == ST_ISSUE) ? itr_q[idx_q] : '0;
    assign bus.dtr_core_rdata = dtr_q;

endmodule

// File: tb/tb_core_dbg_itr.sv
// tb/tb_core_dbg_itr.sv - self-checking bench for core_dbg_itr
module tb_core_dbg_itr;
    localparam int INSN_WIDTH = 32;
    localparam int REG_WIDTH  = 64;
    localparam logic [3:0] A_DBGSC = 4'd0, A_DRUN = 4'd1, A_ITR0 = 4'd2, A_ITR1 = 4'd3;
    localparam logic [3:0] A_ITR2 = 4'd4, A_ITR3 = 4'd5, A_HI = 4'd6, A_LO = 4'd7;

    logic clk;
    logic rst;

    core_dbg_itr_if #(.INSN_WIDTH(INSN_WIDTH), .REG_WIDTH(REG_WIDTH)) bus ();

    core_dbg_itr #(.INSN_WIDTH(INSN_WIDTH), .REG_WIDTH(REG_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_errors;
    logic [31:0] itr_m [4];
    logic [1:0]  len_m;
    bit          err_m;
    bit          busy_m;
    logic [63:0] dtr_m;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) itr_m[i] = 32'd0;
        len_m  = 2'd3;
        err_m  = 1'b0;
        busy_m = 1'b0;
        dtr_m  = 64'd0;
    endtask

    // host write plus the register-map rules applied to the bench's model
    task automatic mwr(input logic [3:0] a, input logic [31:0] d);
        bit halted;
        halted        = bus.core_halted;
        bus.dbg_wr_en = 1'b1;
        bus.dbg_addr  = a;
        bus.dbg_wdata = d;
        tick();
        bus.dbg_wr_en = 1'b0;
        if (a == A_DBGSC) begin
            len_m = d[1:0];
            if (d[2]) err_m = 1'b0;
        end else if (a >= A_ITR0 && a <= A_ITR2) begin
            if (busy_m) err_m = 1'b1;
            else        itr_m[a - A_ITR0] = d;
        end else if (a == A_ITR3) begin
            if (busy_m) err_m = 1'b1;
            else begin
                itr_m[3] = d;
                if (halted) busy_m = 1'b1;
                else        err_m  = 1'b1;
            end
        end else if (a == A_HI) begin
            dtr_m[63:32] = d;
        end else if (a == A_LO) begin
            dtr_m[31:0] = d;
        end
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a);
        logic [31:0] exp;
        exp = (a == A_HI) ? dtr_m[63:32] : (a == A_LO) ? dtr_m[31:0] : 32'd0;
        bus.dbg_rd_en = 1'b1;
        bus.dbg_addr  = a;
        tick();
        bus.dbg_rd_en = 1'b0;
        check_eq(tag, bus.dbg_rdata, exp);
    endtask

    task automatic load_and_go(input logic [31:0] w0, w1, w2, w3);
        mwr(A_ITR0, w0);
        mwr(A_ITR1, w1);
        mwr(A_ITR2, w2);
        mwr(A_ITR3, w3);
    endtask

    // drives itr_ready, records every accepted instruction and compares the
    // observed stream with ITR0..ITR_LEN from the model; leaves the DUT in WAIT
    task automatic run_seq(input int stall, input bit rnd);
        logic [31:0] exp_q[$];
        logic [31:0] obs_q[$];
        logic [31:0] prev;
        bit          pend;
        int          cycles;
        bit          left;
        for (int i = 0; i <= int'(len_m); i++) exp_q.push_back(itr_m[i]);
        pend   = 1'b0;
        cycles = 0;
        left   = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!bus.itr_valid) begin
                left = 1'b1;
                break;
            end
            bus.itr_ready = (k < stall) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (pend) check_eq("itr_hold", bus.itr_insn, prev);
            prev = bus.itr_insn;
            pend = 1'b1;
            if (bus.itr_ready) begin
                obs_q.push_back(bus.itr_insn);
                pend = 1'b0;
            end
            cycles++;
            tick();
        end
        bus.itr_ready = 1'b0;
        check_eq("seq_left_issue", left, 1'b1);
        check_eq("seq_wait_busy", bus.dbg_busy, 1'b1);
        check_eq("seq_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check_eq($sformatf("seq_insn%0d", i), obs_q[i], exp_q[i]);
        if (!rnd) check_eq("seq_cycles", cycles, stall + int'(len_m) + 1);
    endtask

    task automatic finish_seq();
        bus.itr_done = 1'b1;
        tick();
        bus.itr_done = 1'b0;
        busy_m = 1'b0;
        check_eq("busy_after_done", bus.dbg_busy, 1'b0);
    endtask

    initial begin
        logic [3:0]  a;
        logic [31:0] d;
        logic [63:0] cw;
        n_checks = 0;
        n_errors = 0;
        model_reset();
        bus.dbg_wr_en      = 1'b0;
        bus.dbg_rd_en      = 1'b0;
        bus.dbg_addr       = 4'd0;
        bus.dbg_wdata      = 32'd0;
        bus.core_halted    = 1'b0;
        bus.itr_ready      = 1'b0;
        bus.itr_done       = 1'b0;
        bus.dtr_core_wr_en = 1'b0;
        bus.dtr_core_wdata = 64'd0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_rdata", bus.dbg_rdata, 0);
        check_eq("rst_dtr", bus.dtr_core_rdata, 0);
        check_eq("rst_busy", bus.dbg_busy, 0);
        check_eq("rst_err", bus.dbg_err, 0);
        check_eq("rst_halt", bus.halt_req, 0);
        check_eq("rst_resume", bus.resume_req, 0);
        check_eq("rst_valid", bus.itr_valid, 0);
        check_eq("rst_insn", bus.itr_insn, 0);

        // four-instruction sequence at full rate
        bus.core_halted = 1'b1;
        load_and_go(32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193);
        check_eq("seq4_first_valid", bus.itr_valid, 1);
        check_eq("seq4_first_insn", bus.itr_insn, 32'h0000_0013);
        run_seq(0, 1'b0);
        finish_seq();

        // two instructions with three cycles of backpressure
        mwr(A_DBGSC, 32'h1);
        load_and_go($urandom, $urandom, $urandom, $urandom);
        run_seq(3, 1'b0);
        finish_seq();

        // ITR3 while running free: stored, not executed, flagged
        bus.core_halted = 1'b0;
        mwr(A_ITR3, 32'hCAFE_0001);
        check_eq("nohalt_valid", bus.itr_valid, 0);
        check_eq("nohalt_busy", bus.dbg_busy, 0);
        check_eq("nohalt_err", bus.dbg_err, err_m);
        tick();
        check_eq("nohalt_valid2", bus.itr_valid, 0);
        mwr(A_DBGSC, 32'h4);
        check_eq("err_clear", bus.dbg_err, err_m);

        // ITR1 write while busy is dropped
        bus.core_halted = 1'b1;
        mwr(A_DBGSC, 32'h3);
        load_and_go(32'h11, 32'h22, 32'h33, 32'h44);
        mwr(A_ITR1, 32'hBAD0_BAD0);
        check_eq("busy_wr_err", bus.dbg_err, err_m);
        run_seq(0, 1'b0);
        finish_seq();
        mwr(A_DBGSC, 32'h7);

        // DTR host halves, collision, read-during-write
        mwr(A_HI, 32'hDEAD_BEEF);
        mwr(A_LO, 32'h0123_4567);
        check_eq("dtr_host", bus.dtr_core_rdata, 64'hDEAD_BEEF_0123_4567);
        bus.dtr_core_wr_en = 1'b1;
        bus.dtr_core_wdata = 64'h5;
        mwr(A_LO, 32'h9999_9999);
        bus.dtr_core_wr_en = 1'b0;
        dtr_m = 64'h5;
        err_m = 1'b1;
        check_eq("dtr_collide", bus.dtr_core_rdata, 64'h5);
        check_eq("dtr_collide_err", bus.dbg_err, 1);
        rd_chk("dtr_lo_rd", A_LO);
        bus.dbg_rd_en = 1'b1;
        mwr(A_LO, 32'h77);
        bus.dbg_rd_en = 1'b0;
        check_eq("rdw_old", bus.dbg_rdata, 32'h5);
        check_eq("rdw_new", bus.dtr_core_rdata, dtr_m);
        mwr(A_DBGSC, 32'h7);

        // run control
        mwr(A_DRUN, 32'h3);
        check_eq("drun3_halt", bus.halt_req, 1);
        check_eq("drun3_resume", bus.resume_req, 0);
        tick();
        check_eq("drun3_halt_off", bus.halt_req, 0);
        mwr(A_DRUN, 32'h2);
        check_eq("drun2_resume", bus.resume_req, 1);
        check_eq("drun2_halt", bus.halt_req, 0);
        load_and_go($urandom, $urandom, $urandom, $urandom);
        mwr(A_DRUN, 32'h2);
        check_eq("drun2_busy_resume", bus.resume_req, 0);
        run_seq(0, 1'b0);
        finish_seq();

        // abort when the core leaves halt mid-issue
        load_and_go($urandom, $urandom, $urandom, $urandom);
        tick();
        bus.core_halted = 1'b0;
        tick();
        err_m  = 1'b1;
        busy_m = 1'b0;
        check_eq("abort_valid", bus.itr_valid, 0);
        check_eq("abort_busy", bus.dbg_busy, 0);
        check_eq("abort_err", bus.dbg_err, 1);
        bus.core_halted = 1'b1;
        mwr(A_DBGSC, 32'h7);
        check_eq("abort_err_clear", bus.dbg_err, 0);

        // randomized register traffic and sequences
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    a = ($urandom_range(0, 1) != 0) ? A_HI : A_LO;
                    mwr(a, $urandom);
                    check_eq("rnd_host_dtr", bus.dtr_core_rdata, dtr_m);
                end
                1: begin
                    cw = {$urandom, $urandom};
                    bus.dtr_core_wr_en = 1'b1;
                    bus.dtr_core_wdata = cw;
                    tick();
                    bus.dtr_core_wr_en = 1'b0;
                    dtr_m = cw;
                    check_eq("rnd_core_dtr", bus.dtr_core_rdata, dtr_m);
                end
                2: begin
                    cw = {$urandom, $urandom};
                    a  = ($urandom_range(0, 1) != 0) ? A_HI : A_LO;
                    bus.dtr_core_wr_en = 1'b1;
                    bus.dtr_core_wdata = cw;
                    mwr(a, $urandom);
                    bus.dtr_core_wr_en = 1'b0;
                    dtr_m = cw;
                    err_m = 1'b1;
                    check_eq("rnd_collide_dtr", bus.dtr_core_rdata, dtr_m);
                end
                3: begin
                    a = 4'($urandom_range(0, 15));
                    rd_chk("rnd_read", a);
                end
                4: begin
                    a = 4'($urandom_range(8, 15));
                    mwr(a, $urandom);
                    check_eq("rnd_unmapped_dtr", bus.dtr_core_rdata, dtr_m);
                end
                default: begin
                    d = {29'd0, 3'($urandom_range(0, 7))};
                    mwr(A_DBGSC, d);
                    load_and_go($urandom, $urandom, $urandom, $urandom);
                    run_seq($urandom_range(0, 2), 1'b1);
                    finish_seq();
                end
            endcase
            check_eq("rnd_err", bus.dbg_err, err_m);
        end

        // asynchronous reset while waiting for retirement
        mwr(A_LO, 32'hA5A5_0001);
        rd_chk("pre_rst_read", A_LO);
        mwr(A_DBGSC, 32'h3);
        load_and_go($urandom, $urandom, $urandom, $urandom);
        run_seq(0, 1'b0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_eq("arst_busy", bus.dbg_busy, 0);
        check_eq("arst_valid", bus.itr_valid, 0);
        check_eq("arst_insn", bus.itr_insn, 0);
        check_eq("arst_rdata", bus.dbg_rdata, 0);
        check_eq("arst_dtr", bus.dtr_core_rdata, 0);
        check_eq("arst_err", bus.dbg_err, 0);
        check_eq("arst_halt", bus.halt_req, 0);
        check_eq("arst_resume", bus.resume_req, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // stray itr_done in IDLE, then ITR_LEN back at four instructions
        bus.itr_done = 1'b1;
        tick();
        bus.itr_done = 1'b0;
        check_eq("idle_done_busy", bus.dbg_busy, 0);
        mwr(A_ITR3, 32'h0040_0213);
        run_seq(0, 1'b0);
        finish_seq();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/core_dbg_itr.md
# core_dbg_itr

Debug-interface register block for the Tachyon core. It decodes host writes and reads to the 4-bit debug register map: DBGSC, DRUNCTRL, ITR0..ITR3, DTR_HI and DTR_LO. When the host writes ITR3 while the core is halted, it streams the staged instructions one by one into the decode stage over a valid/ready handshake, then waits for the core to report retirement. It also holds the 64-bit DTR shared between the host and instructions running on the core.

## Interface
Parameters:
- INSN_WIDTH, 32, width of an injected instruction (core package value).
- REG_WIDTH, 64, DTR width (core package value).

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dbg_wr_en  in  1  host register write strobe.
- dbg_rd_en  in  1  host register read strobe.
- dbg_addr  in  4  register offset, encoded as DbgIfaceReg (0..7; 8..15 unmapped).
- dbg_wdata  in  32  host write data.
- dbg_rdata  out  32  host read data, registered.
- dbg_busy  out  1  ITR sequence in progress.
- dbg_err  out  1  sticky error flag.
- core_halted  in  1  core is in debug-halt state.
- halt_req  out  1  one-cycle halt request pulse.
- resume_req  out  1  one-cycle resume request pulse.
- itr_valid  out  1  injected instruction valid.
- itr_insn  out  INSN_WIDTH  injected instruction.
- itr_ready  in  1  decode accepts itr_insn.
- itr_done  in  1  pulse: last injected instruction retired.
- dtr_core_wr_en  in  1  core writes the DTR.
- dtr_core_wdata  in  REG_WIDTH  core DTR write data.
- dtr_core_rdata  out  REG_WIDTH  current DTR value.

## Operation
- Reset values:
  - dbg_rdata, dtr_core_rdata, ITR0..ITR3, itr_insn: 0.
  - dbg_busy, dbg_err, halt_req, resume_req, itr_valid: 0.
  - ITR_LEN field: 3, meaning 4 instructions.
  - State: IDLE.
- DBGSC write:
  - bits[1:0] → ITR_LEN (instruction count minus 1).
  - bit2 = 1 clears dbg_err.
  - Other bits ignored.
- DRUNCTRL write:
  - bit0 → halt_req pulse.
  - bit1 → resume_req pulse.
  - If both bits are set, only halt_req pulses.
  - resume is ignored while busy.
- ITR0..ITR2 write: store the word.
  - If busy, the write is dropped and dbg_err is set.
- ITR3 write: store the word, then:
  - If idle and core_halted: go to ISSUE with idx = 0.
  - If core not halted: word is stored, no execution, dbg_err is set.
  - If busy: write is dropped and dbg_err is set.
- FSM:
  - IDLE: waits for a qualifying ITR3 write, as above.
  - ISSUE:
    - itr_valid = 1 and itr_insn = ITR[idx].
    - On valid && ready: if idx == ITR_LEN, go to WAIT, otherwise idx increments.
    - If core_halted drops: itr_valid drops, go to IDLE, set dbg_err.
  - WAIT:
    - itr_valid = 0.
    - On itr_done, go to IDLE.
    - itr_done seen in any other state is ignored.
- dbg_busy = (state != IDLE).
- DTR:
  - Host writes to DTR_HI/DTR_LO update bits [63:32]/[31:0].
  - A core write replaces all 64 bits.
  - If a core write and a host DTR write land in the same cycle, the core write wins and dbg_err is set.
- Reads:
  - DTR_HI/DTR_LO return the matching DTR half.
  - Any other address returns 0.
  - dbg_rdata holds its value when dbg_rd_en = 0.
- Unmapped write addresses (8..15): ignored, no error.

## Timing
- Host write at edge N takes effect at N+1.
- halt_req/resume_req are high for exactly cycle N+1.
- Read: dbg_rd_en at cycle N → dbg_rdata valid from N+1.
- Read-during-write to the same DTR half returns the old value.
- ITR sequence:
  - ITR3 accepted at edge N → itr_valid high in cycle N+1 with ITR0.
  - Back-to-back issue: handshake at edge M → next instruction valid in cycle M+1.
  - itr_valid and itr_insn hold stable until ready.
- After the last handshake the FSM is in WAIT the next cycle.
- itr_done at edge K → dbg_busy low from K+1; a new ITR3 write is accepted from K+1.
- dtr_core_rdata reflects a write on the cycle after it.
- rst asserted mid-sequence: all outputs and state return to reset values immediately; a pending handshake is lost.

## Test plan
- Sequence, ITR_LEN 3:
  - Stimulus: halted, ITR0..3 = 0x00000013, 0x00100093, 0x00200113, 0x00300193; itr_ready = 1.
  - Response: four consecutive valid cycles in order, dbg_busy drops one cycle after itr_done.
- Backpressure:
  - Stimulus: DBGSC = 0x1 (2 instructions), itr_ready low for 3 cycles.
  - Response: ITR0 held stable for 3 cycles, then ITR0 and ITR1 issue; no ITR2 issued.
- Error cases:
  - Stimulus: ITR3 written while not halted.
  - Response: no itr_valid, dbg_err = 1; a DBGSC write of 0x4 clears it.
  - Stimulus: ITR1 written while busy.
  - Response: write dropped, dbg_err = 1.
- DTR:
  - Stimulus: host writes HI = 0xDEADBEEF, LO = 0x01234567.
  - Response: dtr_core_rdata = 0xDEADBEEF01234567.
  - Stimulus: same-cycle core write of 0x5 and host write to LO.
  - Response: DTR = 0x5, dbg_err = 1; a DTR_LO read returns 0x5 on the next cycle.
- Run control:
  - Stimulus: DRUNCTRL = 0x3.
  - Response: halt_req pulses for one cycle, no resume_req.
  - Stimulus: DRUNCTRL = 0x2 while busy.
  - Response: no resume_req.
- Abort and reset:
  - Stimulus: core_halted drops during ISSUE.
  - Response: itr_valid = 0 next cycle, IDLE, dbg_err = 1.
  - Stimulus: rst asserted in WAIT.
  - Response: all outputs 0 asynchronously.
